// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package spram_arb_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index width that stays at least one bit wide even for tiny requester counts.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter
    import spram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = clog2_safe(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     winner
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin sharing of one single-port RAM between NUM_REQ requesters,
// with zero-fill after reset and read-data routing back to the issuer.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          init_done,
    output logic                          mem_ena,
    output logic                          mem_wea,
    output logic [ADDR_WIDTH-1:0]         mem_addra,
    output logic [DATA_WIDTH-1:0]         mem_dina,
    output logic                          mem_rsta,
    input  logic [DATA_WIDTH-1:0]         mem_douta
);

    localparam int                    IDW       = clog2_safe(NUM_REQ);
    localparam int                    PIPE_D    = 1 + READ_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      init_cnt_q, init_cnt_d;
    logic                       init_done_q, init_done_d;
    logic [IDW-1:0]             ptr_q, ptr_d;
    logic                       mem_ena_q, mem_ena_d;
    logic                       mem_wea_q, mem_wea_d;
    logic [ADDR_WIDTH-1:0]      mem_addra_q, mem_addra_d;
    logic [DATA_WIDTH-1:0]      mem_dina_q, mem_dina_d;
    logic [PIPE_D-1:0]          pipe_vld_q, pipe_vld_d;
    logic [PIPE_D-1:0][IDW-1:0] pipe_id_q, pipe_id_d;

    logic [ADDR_WIDTH-1:0]      addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]      wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]         grant;
    logic [IDW-1:0]             winner;
    logic                       granted;
    logic                       grant_we;
    logic                       run;
    logic                       rsp_vld;
    logic [IDW-1:0]             rsp_id;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign run = (state_q == RUN);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (ptr_q),
        .en     (run),
        .grant  (grant),
        .winner (winner)
    );

    assign granted   = |grant;
    assign grant_we  = req_we[winner];
    assign req_ready = grant;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        ptr_d       = ptr_q;
        mem_ena_d   = 1'b0;
        mem_wea_d   = 1'b0;
        mem_addra_d = mem_addra_q;
        mem_dina_d  = mem_dina_q;
        case (state_q)
            INIT: begin
                mem_ena_d   = 1'b1;
                mem_wea_d   = 1'b1;
                mem_addra_d = init_cnt_q;
                mem_dina_d  = '0;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            default: begin
                if (granted) begin
                    mem_ena_d   = 1'b1;
                    mem_wea_d   = grant_we;
                    mem_addra_d = addr_arr[winner];
                    mem_dina_d  = wdata_arr[winner];
                    ptr_d       = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
        endcase
    end

    // Read tags ride alongside the RAM latency so data returns to its issuer.
    assign pipe_vld_d = {pipe_vld_q[PIPE_D-2:0], granted & ~grant_we};
    assign pipe_id_d  = {pipe_id_q[PIPE_D-2:0], winner};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            ptr_q       <= '0;
            mem_ena_q   <= 1'b0;
            mem_wea_q   <= 1'b0;
            mem_addra_q <= '0;
            mem_dina_q  <= '0;
            pipe_vld_q  <= '0;
            pipe_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            ptr_q       <= ptr_d;
            mem_ena_q   <= mem_ena_d;
            mem_wea_q   <= mem_wea_d;
            mem_addra_q <= mem_addra_d;
            mem_dina_q  <= mem_dina_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_id_q   <= pipe_id_d;
        end
    end

    assign rsp_vld = pipe_vld_q[PIPE_D-1];
    assign rsp_id  = pipe_id_q[PIPE_D-1];

    always_comb begin
        rsp_valid = '0;
        if (rsp_vld) begin
            rsp_valid[rsp_id] = 1'b1;
        end
    end

    // Gated so the shared data bus reads zero outside a response pulse.
    assign rsp_rdata = rsp_vld ? mem_douta : '0;

    assign init_done = init_done_q;
    assign mem_ena   = mem_ena_q;
    assign mem_wea   = mem_wea_q;
    assign mem_addra = mem_addra_q;
    assign mem_dina  = mem_dina_q;
    assign mem_rsta  = 1'b0;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural single-port RAM attached.
module tb_spram_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int ADDR_WIDTH   = 10;
    localparam int DATA_WIDTH   = 64;
    localparam int DEPTH        = 16;
    localparam int READ_LATENCY = 1;
    localparam int RAM_AW       = $clog2(DEPTH);

    localparam logic [63:0] D_BEEF = 64'hDEAD_BEEF;
    localparam logic [63:0] D_77   = 64'h0000_0000_0000_0077;
    localparam logic [63:0] D_99   = 64'h1234_5678_0000_0099;
    localparam logic [63:0] D_AA   = 64'h0BAD_F00D_0000_00AA;

    logic                          clk;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          init_done;
    logic                          mem_ena;
    logic                          mem_wea;
    logic [ADDR_WIDTH-1:0]         mem_addra;
    logic [DATA_WIDTH-1:0]         mem_dina;
    logic                          mem_rsta;
    logic [DATA_WIDTH-1:0]         mem_douta;

    spram_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .mem_ena   (mem_ena),
        .mem_wea   (mem_wea),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_rsta  (mem_rsta),
        .mem_douta (mem_douta)
    );

    // Behavioural RAM: READ_LATENCY registered read stages, preloaded with a
    // non-zero pattern so the zero-fill is observable.
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] rd_p1, rd_p2;
    logic                  fill_en;

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= {32'hA5A5_A5A5, 32'(i)};
        end else if (mem_ena) begin
            if (mem_wea) ram[mem_addra[RAM_AW-1:0]] <= mem_dina;
            rd_p1 <= ram[mem_addra[RAM_AW-1:0]];
        end
        rd_p2 <= rd_p1;
    end
    assign mem_douta = (READ_LATENCY == 2) ? rd_p2 : rd_p1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]       valid;
        logic [3:0]       we;
        logic [3:0][9:0]  addr;
        logic [3:0][63:0] wdata;
        logic [3:0]       exp_ready;
        logic [3:0]       exp_rsp;
        logic [63:0]      exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] v, input logic [3:0] we, input logic [3:0][9:0] a,
                       input logic [3:0][63:0] d, input logic [3:0] er, input logic [3:0] ers,
                       input logic [63:0] erd);
        vec_t x;
        x.valid = v; x.we = we; x.addr = a; x.wdata = d;
        x.exp_ready = er; x.exp_rsp = ers; x.exp_rdata = erd;
        vecs.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_ena"},   64'(mem_ena),   64'd0);
        chk({tag, "_mem_wea"},   64'(mem_wea),   64'd0);
        chk({tag, "_mem_addra"}, 64'(mem_addra), 64'd0);
        chk({tag, "_mem_dina"},  mem_dina,       64'd0);
        chk({tag, "_mem_rsta"},  64'(mem_rsta),  64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata,      64'd0);
        chk({tag, "_init_done"}, 64'(init_done), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    endtask

    // Counts cycles from reset release to init_done, checking INIT behaviour on the way.
    task automatic wait_init(input string tag);
        int cycles;
        int bad_ready;
        int bad_ena;
        cycles = 0; bad_ready = 0; bad_ena = 0;
        while (cycles < 64) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (init_done) break;
            if (req_ready !== '0) bad_ready++;
            if (!(mem_ena && mem_wea && mem_dina == '0)) bad_ena++;
        end
        chk({tag, "_cycles"},     64'(cycles),    64'(DEPTH));
        chk({tag, "_ready_low"},  64'(bad_ready), 64'd0);
        chk({tag, "_zero_write"}, 64'(bad_ena),   64'd0);
    endtask

    task automatic read_check(input int id, input logic [9:0] a, input logic [63:0] exp,
                              input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        @(posedge clk); #1;
        req_valid = oh; req_we = '0; req_addr = '0;
        req_addr[id*ADDR_WIDTH +: ADDR_WIDTH] = a;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(req_ready), 64'(oh));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk({tag, "_rsp_early"}, 64'(rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
        chk({tag, "_rsp_rdata"}, rsp_rdata, exp);
    endtask

    initial begin
        logic [3:0]       prev_ready;
        logic [3:0]       prev_we;
        logic [3:0][9:0]  prev_addr;
        logic [9:0]       exp_addr;
        int               bad_rsp;

        rst_n = 1'b0; fill_en = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        // Directed cycle table: row r response expected 2 rows after its grant.
        add(4'b0010, 4'b0010, {10'd0, 10'd0, 10'd3, 10'd0}, {64'd0, 64'd0, D_BEEF, 64'd0}, 4'b0010, 4'b0000, 64'd0);
        add(4'b0100, 4'b0000, {10'd0, 10'd3, 10'd0, 10'd0}, '0, 4'b0100, 4'b0000, 64'd0);
        add(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0000, 64'd0);
        add(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0100, D_BEEF);
        add(4'b1000, 4'b1000, {10'd7, 10'd0, 10'd0, 10'd0}, {D_77, 64'd0, 64'd0, 64'd0}, 4'b1000, 4'b0000, 64'd0);
        for (int k = 0; k < 8; k++) begin
            logic [3:0]  ers;
            logic [63:0] erd;
            ers = 4'b0000; erd = 64'd0;
            if (k >= 2) begin
                ers = 4'b0001 << ((k - 2) % 4);
                erd = (((k - 2) % 4) == 1) ? D_77 : (((k - 2) % 4) == 2) ? 64'd0 : D_BEEF;
            end
            add(4'b1111, 4'b0000, {10'd3, 10'd5, 10'd7, 10'd3}, '0, 4'b0001 << (k % 4), ers, erd);
        end
        add(4'b1000, 4'b0000, {10'd7, 10'd0, 10'd0, 10'd0}, '0, 4'b1000, 4'b0100, 64'd0);
        add(4'b1000, 4'b0000, {10'd7, 10'd0, 10'd0, 10'd0}, '0, 4'b1000, 4'b1000, D_BEEF);
        for (int k = 0; k < 6; k++)
            add(4'b1000, 4'b0000, {10'd7, 10'd0, 10'd0, 10'd0}, '0, 4'b1000, 4'b1000, D_77);
        add(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b1000, D_77);
        add(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b1000, D_77);
        add(4'b0011, 4'b0011, {10'd0, 10'd0, 10'd10, 10'd9}, {64'd0, 64'd0, D_AA, D_99}, 4'b0001, 4'b0000, 64'd0);
        add(4'b0010, 4'b0010, {10'd0, 10'd0, 10'd10, 10'd9}, {64'd0, 64'd0, D_AA, D_99}, 4'b0010, 4'b0000, 64'd0);
        add(4'b0001, 4'b0000, {10'd0, 10'd0, 10'd0, 10'd9}, '0, 4'b0001, 4'b0000, 64'd0);
        add(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0000, 64'd0);
        add(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0001, D_99);
        add(4'b0010, 4'b0000, {10'd0, 10'd0, 10'd10, 10'd0}, '0, 4'b0010, 4'b0000, 64'd0);
        add(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0000, 64'd0);
        add(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0010, D_AA);

        // Reset state, then requester 0 asks for addr 5 while INIT runs.
        repeat (2) @(posedge clk);
        #1 fill_en = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        req_valid = 4'b0001; req_we = '0; req_addr = '0; req_addr[9:0] = 10'd5;
        @(posedge clk); #1 rst_n = 1'b1;
        wait_init("init1");
        chk("init1_first_grant", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("init1_rsp_early", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("init1_rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("init1_rsp_zero",  rsp_rdata,      64'd0);

        prev_ready = '0; prev_we = '0; prev_addr = '0;
        foreach (vecs[r]) begin
            @(posedge clk); #1;
            req_valid = vecs[r].valid;
            req_we    = vecs[r].we;
            req_addr  = vecs[r].addr;
            req_wdata = vecs[r].wdata;
            @(negedge clk);
            chk($sformatf("row%0d_ready", r), 64'(req_ready), 64'(vecs[r].exp_ready));
            chk($sformatf("row%0d_rsp", r),   64'(rsp_valid), 64'(vecs[r].exp_rsp));
            if (vecs[r].exp_rsp != '0)
                chk($sformatf("row%0d_rdata", r), rsp_rdata, vecs[r].exp_rdata);
            chk($sformatf("row%0d_mem_ena", r), 64'(mem_ena), 64'(|prev_ready));
            if (prev_ready != '0) begin
                exp_addr = '0;
                for (int i = 0; i < 4; i++) if (prev_ready[i]) exp_addr = prev_addr[i];
                chk($sformatf("row%0d_mem_wea", r),   64'(mem_wea),   64'(|(prev_ready & prev_we)));
                chk($sformatf("row%0d_mem_addr", r),  64'(mem_addra), 64'(exp_addr));
            end
            prev_ready = vecs[r].exp_ready;
            prev_we    = vecs[r].we;
            prev_addr  = vecs[r].addr;
        end

        // Two reads in flight, then an asynchronous reset mid-cycle.
        @(posedge clk); #1;
        req_valid = 4'b0001; req_we = '0; req_addr = '0; req_addr[9:0] = 10'd1;
        @(negedge clk);
        chk("mid_read1_ready", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_addr[9:0] = 10'd2;
        @(negedge clk);
        chk("mid_read2_ready", 64'(req_ready), 64'b0001);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        req_valid = '0; req_addr = '0; req_wdata = '0;
        bad_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== '0) bad_rsp++;
        end
        chk("midrst_no_rsp", 64'(bad_rsp), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_init("init2");
        read_check(2, 10'd3, 64'd0, "rezero_a3");
        read_check(0, 10'd9, 64'd0, "rezero_a9");
        read_check(3, 10'd7, 64'd0, "rezero_a7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
